// File: rtl/sw_input_debounce_pkg.sv
// rtl/sw_input_debounce_pkg.sv - board-level constants shared by the switch input stage
//
// Purpose: single home for the switch-vector width and the debounce window
//   lengths used on the board and in simulation.
// Ports: none (package).
package sw_input_debounce_pkg;

  localparam int SW_WIDTH              = 4;
  localparam int DEBOUNCE_CYCLES_BOARD = 1000000;  // 10 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_SIM   = 8;
  localparam int SYNC_STAGES_DEFAULT   = 2;
  localparam int CNT_W_DEFAULT         = 20;

endpackage

// File: rtl/sw_input_debounce_sync_nff.sv
// rtl/sw_input_debounce_sync_nff.sv - multi-bit N-flop synchroniser
//
// Purpose: brings an asynchronous vector into the clk domain through
//   SYNC_STAGES flops per bit. Bits may land on different cycles; the
//   downstream debouncer treats the vector as a whole, which absorbs that skew.
// Ports:
//   clk   in  1      sampling clock
//   rst   in  1      asynchronous reset, active-high; clears every stage
//   din   in  WIDTH  asynchronous input vector
//   dout  out WIDTH  output of the last stage
module sync_nff #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[SYNC_STAGES-1];

endmodule

// File: rtl/sw_input_debounce.sv
// rtl/sw_input_debounce.sv - synchronise and debounce the slide-switch vector
//
// Purpose: board-input stage ahead of the input-k generator. The raw switches
//   are synchronised, debounced as one vector, and each accepted change is
//   announced with a one-cycle strobe plus a valid/ack handshake.
// Ports:
//   clk         in  1      system clock
//   rst         in  1      asynchronous reset, active-high
//   SW_raw      in  WIDTH  raw switch pins, asynchronous to clk
//   SW          out WIDTH  debounced switch code
//   sw_changed  out 1      one-cycle pulse when SW takes a new value
//   sw_valid    out 1      new code pending, held until sw_ack
//   sw_ack      in  1      consumer acknowledge, only honoured while sw_valid=1
module sw_input_debounce
  import sw_input_debounce_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] SW_raw,
  output logic [WIDTH-1:0] SW,
  output logic             sw_changed,
  output logic             sw_valid,
  input  logic             sw_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT    = 2'd1,
    UPDATE   = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cand,    cand_nxt;
  logic [WIDTH-1:0] sw_nxt;
  logic [CNT_W-1:0] cnt,     cnt_nxt;
  logic             changed_nxt;
  logic             valid_nxt;
  state_t           state,   state_nxt;

  sync_nff #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (SW_raw),
    .dout (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      SW         <= '0;
      sw_changed <= 1'b0;
      sw_valid   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cand       <= cand_nxt;
      cnt        <= cnt_nxt;
      SW         <= sw_nxt;
      sw_changed <= changed_nxt;
      sw_valid   <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    cnt_nxt     = cnt;
    sw_nxt      = SW;
    changed_nxt = 1'b0;
    valid_nxt   = sw_valid;

    unique case (state)
      IDLE: begin
        if (s != SW) begin
          cand_nxt  = s;
          cnt_nxt   = '0;
          state_nxt = COUNT;
        end
      end

      COUNT: begin
        if (s == SW) begin
          // Input bounced back to the accepted code: drop the candidate.
          state_nxt = IDLE;
        end else if (s != cand) begin
          // A different pattern appeared mid-window: restart on it.
          cand_nxt = s;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = UPDATE;
        end else begin
          // Counter stops advancing at CNT_LAST, so it cannot wrap.
          cnt_nxt = cnt + 1'b1;
        end
      end

      UPDATE: begin
        sw_nxt      = cand;
        changed_nxt = 1'b1;
        valid_nxt   = 1'b1;
        state_nxt   = WAIT_ACK;
      end

      WAIT_ACK: begin
        // Input is not watched here; any new difference is picked up in IDLE.
        if (sw_ack) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sw_input_debounce.sv
// tb/tb_sw_input_debounce.sv - self-checking bench for sw_input_debounce
module tb_sw_input_debounce;

  localparam int W   = 4;
  localparam int DEB = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] SW_raw = '0;
  logic [W-1:0] SW;
  logic         sw_changed;
  logic         sw_valid;
  logic         sw_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int s0;
  logic prev_changed = 1'b0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] exp_sw;

  sw_input_debounce #(
    .WIDTH           (W),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SW_raw     (SW_raw),
    .SW         (SW),
    .sw_changed (sw_changed),
    .sw_valid   (sw_valid),
    .sw_ack     (sw_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance n rising edges, then sample 1 time unit later
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack();
    sw_ack = 1'b1;
    step(1);
    sw_ack = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, input int max_cycles);
    int start;
    int n;
    start = strobe_cnt;
    n = 0;
    while (strobe_cnt == start && n < max_cycles) begin
      step(1);
      n++;
    end
    chk(tag, 32'(strobe_cnt != start), 32'd1);
  endtask

  // Scoreboard: every strobe must match the oldest expected code.
  always @(negedge clk) begin
    if (!rst && sw_changed) begin
      strobe_cnt++;
      chk("changed_pulse_width", 32'(prev_changed), 32'd0);
      chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_sw = exp_q.pop_front();
        chk("strobe_sw_value", 32'(SW), 32'(exp_sw));
      end
    end
    prev_changed <= sw_changed;
  end

  initial begin
    // power-on reset
    step(3);
    chk("reset_sw", 32'(SW), 32'h0);
    chk("reset_valid", 32'(sw_valid), 32'd0);
    chk("reset_changed", 32'(sw_changed), 32'd0);
    rst = 1'b0;
    s0 = strobe_cnt;
    step(20);
    chk("idle_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // 0000 -> 0101: exact 12-edge latency, pulse and held valid
    SW_raw = 4'b0101;
    exp_q.push_back(4'b0101);
    step(11);
    chk("t2_sw_before", 32'(SW), 32'h0);
    chk("t2_changed_before", 32'(sw_changed), 32'd0);
    step(1);
    chk("t2_sw_after", 32'(SW), 32'h5);
    chk("t2_changed_after", 32'(sw_changed), 32'd1);
    chk("t2_valid_after", 32'(sw_valid), 32'd1);
    step(1);
    chk("t2_changed_drop", 32'(sw_changed), 32'd0);
    step(5);
    chk("t2_valid_held", 32'(sw_valid), 32'd1);
    ack();
    chk("t2_valid_cleared", 32'(sw_valid), 32'd0);
    step(3);
    sw_ack = 1'b1;  // ack while not valid: no effect
    step(2);
    sw_ack = 1'b0;
    chk("t2_stray_ack_sw", 32'(SW), 32'h5);
    chk("t2_stray_ack_valid", 32'(sw_valid), 32'd0);

    // bouncing 0000 <-> 0011 every 3 clocks, settles on 0011
    s0 = strobe_cnt;
    for (int i = 0; i < 13; i++) begin
      SW_raw = (i % 2 == 1) ? 4'b0000 : 4'b0011;
      step(3);
    end
    chk("t3_no_strobe_while_bouncing", 32'(strobe_cnt - s0), 32'd0);
    exp_q.push_back(4'b0011);
    wait_strobe("t3_strobe_timeout", 30);
    step(20);
    chk("t3_one_strobe", 32'(strobe_cnt - s0), 32'd1);
    chk("t3_sw", 32'(SW), 32'h3);
    ack();

    // return to 0000, then a 5-clock glitch to 0111
    SW_raw = 4'b0000;
    exp_q.push_back(4'b0000);
    wait_strobe("t4_setup_timeout", 30);
    ack();
    s0 = strobe_cnt;
    SW_raw = 4'b0111;
    step(5);
    SW_raw = 4'b0000;
    step(30);
    chk("t4_glitch_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("t4_sw", 32'(SW), 32'h0);

    // hold off ack while input moves on
    SW_raw = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_strobe("t5_first_timeout", 30);
    s0 = strobe_cnt;
    SW_raw = 4'b0110;
    step(30);
    chk("t5_valid_held", 32'(sw_valid), 32'd1);
    chk("t5_sw_held", 32'(SW), 32'h2);
    chk("t5_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    exp_q.push_back(4'b0110);
    ack();
    step(9);
    chk("t5_sw_before", 32'(SW), 32'h2);
    step(1);
    chk("t5_sw_after", 32'(SW), 32'h6);
    chk("t5_valid_after", 32'(sw_valid), 32'd1);

    // reset mid-run abandons the pending code
    SW_raw = 4'b0000;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t1_rst_sw", 32'(SW), 32'h0);
    chk("t1_rst_valid", 32'(sw_valid), 32'd0);
    chk("t1_rst_changed", 32'(sw_changed), 32'd0);
    step(2);
    rst = 1'b0;
    s0 = strobe_cnt;
    step(20);
    chk("t1_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("t1_sw_zero", 32'(SW), 32'h0);

    // reset at count 4, then a full window from release
    SW_raw = 4'b0001;
    exp_q.push_back(4'b0001);
    step(7);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_rst_sw", 32'(SW), 32'h0);
    step(2);
    rst = 1'b0;
    exp_q.push_back(4'b0001);
    step(11);
    chk("t6_sw_before", 32'(SW), 32'h0);
    step(1);
    chk("t6_sw_after", 32'(SW), 32'h1);
    chk("t6_changed_after", 32'(sw_changed), 32'd1);
    step(3);
    chk("t6_scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
